gate_resp_checker: RTL and testbench
====================================

Name: gate_resp_checker

Overview:
- Downstream self-check stage for the two-input basic-gate block (not/nor/or/and/nand/xor/xnor).
- Consumes each applied (a, b) vector plus the seven gate outputs, computes golden values, and compares per gate.
- Accumulates vector and error counts and captures the first failure.
- Reports pass/fail once a programmed number of vectors has been checked.

Parameters:
- NUM_VECTORS, 4, vectors to check per run (min 1)
- CNT_W, 8, width of vec_cnt; must hold NUM_VECTORS
- ERR_W, 8, width of err_cnt; saturating

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run
- in_valid  in  1  vector plus gate outputs valid this cycle
- a  in  1  gate input a
- b  in  1  gate input b
- gates  in  7  DUT outputs: [6]=not_g(~a), [5]=nor_g, [4]=or_g, [3]=and_g, [2]=nand_g, [1]=xor_g, [0]=xnor_g
- busy  out  1  run in progress
- done  out  1  run complete; level
- pass  out  1  valid while done; 1 = err_cnt==0
- vec_cnt  out  CNT_W  vectors checked this run
- err_cnt  out  ERR_W  failing vectors this run; saturates at all-ones
- fail_seen  out  1  at least one failure captured
- first_fail_ab  out  2  {a,b} of the first failing vector
- first_fail_mask  out  7  per-gate mismatch bits of the first failing vector

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE.
  - All outputs go to 0, including counters, masks and flags.
  - A reset mid-run abandons the run; no done is produced.
- Golden values, combinational from a and b:
  - exp = {~a, ~(a|b), a|b, a&b, ~(a&b), a^b, ~(a^b)}
  - mism = gates ^ exp
  - A vector fails if mism != 0.
- States:
  - IDLE: busy=0, done=0. start moves to RUN and clears vec_cnt, err_cnt, fail_seen, first_fail_ab and first_fail_mask.
  - RUN: busy=1. Each cycle with in_valid=1 checks one vector:
    - vec_cnt increments.
    - On fail, err_cnt increments and saturates at 2^ERR_W-1.
    - On the first fail (fail_seen=0), first_fail_ab and first_fail_mask are captured and fail_seen is set.
    - When the accepted vector is number NUM_VECTORS, the next state is DONE.
  - DONE: busy=0, done=1, pass=(err_cnt==0). All results hold until start or rst. start in DONE behaves as start in IDLE: clear, then RUN.
- Ignored inputs:
  - in_valid outside RUN.
  - start while in RUN.
- Latency:
  - Results for a vector accepted on edge N are visible after edge N.
  - On the edge accepting the final vector, busy falls, done rises and pass is valid together.
- Simultaneous events:
  - start and in_valid in the same IDLE/DONE cycle: the run starts; the vector is not counted.
  - rst has priority over everything.
- Counters never wrap within a run. vec_cnt is bounded by NUM_VECTORS.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: GATE_RESP_CHECKER_COVER_EN
- When defined:
  - Adds output cover_map[3:0]. Bit {a,b} is set when that input combination is checked in RUN.
  - Cleared by start and rst.
  - pass additionally requires cover_map==4'b1111.
- When undefined:
  - No cover_map port or logic.
  - pass depends on err_cnt only.

Decomposition:
- Shared package gate_chk_pkg holds:
  - Gate bit-index constants GATE_NOT=6 through GATE_XNOR=0.
  - State enum IDLE/RUN/DONE.
  - Function golden_gates(a,b) returning 7 bits.
- Sub-module gate_golden: combinational exp/mism generator, reusable by other gate-level checkers.
- The FSM and counters stay in the top module.

Test Plan:
- Correct DUT, NUM_VECTORS=4, start then vectors 00,01,10,11 with correct gates:
  - Expected: done=1, pass=1, vec_cnt=4, err_cnt=0, fail_seen=0.
- Fault on xor_g forced to 0 at vector {a,b}=01:
  - Expected: err_cnt=1, first_fail_ab=2'b01, first_fail_mask=7'b0000010, pass=0.
- Faults on both 10 (and_g flipped) and 11 (nand_g flipped):
  - Expected: err_cnt=2, first_fail_ab=2'b10, first_fail_mask=7'b0001000.
- in_valid gaps (vectors on alternate cycles), in_valid before start, and start asserted mid-RUN:
  - Expected: only in-RUN valids are counted, vec_cnt=4 at done, and the mid-run start is ignored.
- rst after 2 vectors:
  - Expected: all outputs 0 and IDLE.
  - A new run of 4 clean vectors then gives pass=1.
- ERR_W=2, NUM_VECTORS=6, all faulty:
  - Expected: err_cnt saturates at 3, pass=0.
- COVER_EN variant, vectors 00,00,01,01 all correct:
  - Expected: cover_map=4'b0011, pass=0.

Source files
------------

// File: rtl/gate_chk_pkg.sv
// ----------------------------------------------------------------------------
// gate_chk_pkg
//   Shared definitions for checkers of the two-input basic-gate block.
//   - GATE_* : bit positions of each gate output inside the 7-bit gate bus
//   - chk_state_t : run-control states of a checker (IDLE / RUN / DONE)
//   - golden_gates(a, b) : reference values of all seven gates, packed
//     in the same bit order as the gate bus.
// ----------------------------------------------------------------------------
package gate_chk_pkg;

    localparam int GATE_NOT  = 6;
    localparam int GATE_NOR  = 5;
    localparam int GATE_OR   = 4;
    localparam int GATE_AND  = 3;
    localparam int GATE_NAND = 2;
    localparam int GATE_XOR  = 1;
    localparam int GATE_XNOR = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } chk_state_t;

    function automatic logic [6:0] golden_gates(input logic a, input logic b);
        logic [6:0] g;
        g            = '0;
        g[GATE_NOT]  = ~a;
        g[GATE_NOR]  = ~(a | b);
        g[GATE_OR]   = a | b;
        g[GATE_AND]  = a & b;
        g[GATE_NAND] = ~(a & b);
        g[GATE_XOR]  = a ^ b;
        g[GATE_XNOR] = ~(a ^ b);
        return g;
    endfunction

endpackage

// File: rtl/gate_golden.sv
// ----------------------------------------------------------------------------
// gate_golden
//   Combinational comparator for one applied vector of the basic-gate block.
//   Ports:
//     a, b   in   gate inputs of the applied vector
//     gates  in   observed gate outputs, bit order as in gate_chk_pkg
//     mism   out  per-gate mismatch (observed xor golden)
//     fail   out  1 when any gate mismatches
// ----------------------------------------------------------------------------
module gate_golden
    import gate_chk_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic [6:0] gates,
    output logic [6:0] mism,
    output logic       fail
);

    logic [6:0] exp_gates;

    assign exp_gates = golden_gates(a, b);
    assign mism      = gates ^ exp_gates;
    assign fail      = |mism;

endmodule

// File: rtl/gate_resp_checker.sv
// ----------------------------------------------------------------------------
// gate_resp_checker
//   Self-check stage for the two-input basic-gate block. A start pulse opens
//   a run; every in_valid cycle during the run checks one (a, b, gates)
//   vector. After NUM_VECTORS vectors the run ends with done/pass.
//   Optional build macro: GATE_RESP_CHECKER_COVER_EN adds cover_map and makes
//   pass also require that all four {a,b} combinations were checked.
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     start             one-cycle pulse, begins a run from IDLE or DONE
//     in_valid, a, b    vector valid strobe and gate inputs
//     gates[6:0]        observed gate outputs (not,nor,or,and,nand,xor,xnor)
//     busy, done, pass  run status (pass valid while done)
//     vec_cnt, err_cnt  vectors checked / failing vectors (saturating)
//     fail_seen, first_fail_ab, first_fail_mask   first-failure capture
//     cover_map[3:0]    (macro only) {a,b} combinations checked this run
// ----------------------------------------------------------------------------
module gate_resp_checker
    import gate_chk_pkg::*;
#(
    parameter int NUM_VECTORS = 4,
    parameter int CNT_W       = 8,
    parameter int ERR_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic             a,
    input  logic             b,
    input  logic [6:0]       gates,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] vec_cnt,
    output logic [ERR_W-1:0] err_cnt,
    output logic             fail_seen,
    output logic [1:0]       first_fail_ab,
    output logic [6:0]       first_fail_mask
`ifdef GATE_RESP_CHECKER_COVER_EN
   ,output logic [3:0]       cover_map
`endif
);

    chk_state_t       state, state_next;
    logic [6:0]       mism;
    logic             vec_fail;
    logic [CNT_W-1:0] vec_cnt_next;
    logic [ERR_W-1:0] err_cnt_next;
    logic             fail_seen_next;
    logic [1:0]       first_ab_next;
    logic [6:0]       first_mask_next;
    logic             cover_ok;
`ifdef GATE_RESP_CHECKER_COVER_EN
    logic [3:0]       cover_next;
`endif

    gate_golden u_golden (
        .a     (a),
        .b     (b),
        .gates (gates),
        .mism  (mism),
        .fail  (vec_fail)
    );

    // NOTE: state and result registers use non-blocking assignments so every
    // flop samples the pre-edge values; blocking here would create races.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: every output of this block gets a hold/default value first,
        // so no path through the case leaves a signal unassigned (no latch).
        state_next      = state;
        vec_cnt_next    = vec_cnt;
        err_cnt_next    = err_cnt;
        fail_seen_next  = fail_seen;
        first_ab_next   = first_fail_ab;
        first_mask_next = first_fail_mask;
`ifdef GATE_RESP_CHECKER_COVER_EN
        cover_next      = cover_map;
`endif
        case (state)
            IDLE, DONE: begin
                // A vector presented together with start is not counted.
                if (start) begin
                    state_next      = RUN;
                    vec_cnt_next    = '0;
                    err_cnt_next    = '0;
                    fail_seen_next  = 1'b0;
                    first_ab_next   = '0;
                    first_mask_next = '0;
`ifdef GATE_RESP_CHECKER_COVER_EN
                    cover_next      = '0;
`endif
                end
            end
            RUN: begin
                if (in_valid) begin
                    vec_cnt_next = vec_cnt + CNT_W'(1);
                    if (vec_fail) begin
                        if (err_cnt != {ERR_W{1'b1}})
                            err_cnt_next = err_cnt + ERR_W'(1);
                        if (!fail_seen) begin
                            fail_seen_next  = 1'b1;
                            first_ab_next   = {a, b};
                            first_mask_next = mism;
                        end
                    end
`ifdef GATE_RESP_CHECKER_COVER_EN
                    cover_next[{a, b}] = 1'b1;
`endif
                    if (vec_cnt == CNT_W'(NUM_VECTORS - 1))
                        state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef GATE_RESP_CHECKER_COVER_EN
    assign cover_ok = (cover_next == 4'b1111);
`else
    assign cover_ok = 1'b1;
`endif

    // busy/done/pass are registered from the next state so they change on
    // the same edge as the state itself.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            vec_cnt         <= '0;
            err_cnt         <= '0;
            fail_seen       <= 1'b0;
            first_fail_ab   <= '0;
            first_fail_mask <= '0;
`ifdef GATE_RESP_CHECKER_COVER_EN
            cover_map       <= '0;
`endif
        end else begin
            busy            <= (state_next == RUN);
            done            <= (state_next == DONE);
            pass            <= (state_next == DONE) && (err_cnt_next == '0) && cover_ok;
            vec_cnt         <= vec_cnt_next;
            err_cnt         <= err_cnt_next;
            fail_seen       <= fail_seen_next;
            first_fail_ab   <= first_ab_next;
            first_fail_mask <= first_mask_next;
`ifdef GATE_RESP_CHECKER_COVER_EN
            cover_map       <= cover_next;
`endif
        end
    end

endmodule

// File: tb/tb_gate_resp_checker.sv
// ----------------------------------------------------------------------------
// tb_gate_resp_checker
//   Self-checking bench for gate_resp_checker. Two instances: dut (default
//   parameters) and dut_sat (NUM_VECTORS=6, ERR_W=2) for counter saturation.
//   Build with or without GATE_RESP_CHECKER_COVER_EN.
// ----------------------------------------------------------------------------
module tb_gate_resp_checker;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // main instance
    logic       start = 1'b0, in_valid = 1'b0, a = 1'b0, b = 1'b0;
    logic [6:0] gates = '0;
    logic       busy, done, pass, fail_seen;
    logic [7:0] vec_cnt, err_cnt;
    logic [1:0] first_fail_ab;
    logic [6:0] first_fail_mask;
    logic [3:0] cover_map;

    // saturation instance
    logic       s_start = 1'b0, s_valid = 1'b0, s_a = 1'b0, s_b = 1'b0;
    logic [6:0] s_gates = '0;
    logic       s_busy, s_done, s_pass, s_fail_seen;
    logic [7:0] s_vec_cnt;
    logic [1:0] s_err_cnt;
    logic [1:0] s_first_ab;
    logic [6:0] s_first_mask;
    logic [3:0] s_cover_map;

`ifndef GATE_RESP_CHECKER_COVER_EN
    assign cover_map   = 4'b0000;
    assign s_cover_map = 4'b0000;
`endif

    gate_resp_checker dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .a(a), .b(b),
        .gates(gates), .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt),
        .err_cnt(err_cnt), .fail_seen(fail_seen), .first_fail_ab(first_fail_ab),
        .first_fail_mask(first_fail_mask)
`ifdef GATE_RESP_CHECKER_COVER_EN
       ,.cover_map(cover_map)
`endif
    );

    gate_resp_checker #(.NUM_VECTORS(6), .CNT_W(8), .ERR_W(2)) dut_sat (
        .clk(clk), .rst(rst), .start(s_start), .in_valid(s_valid), .a(s_a), .b(s_b),
        .gates(s_gates), .busy(s_busy), .done(s_done), .pass(s_pass), .vec_cnt(s_vec_cnt),
        .err_cnt(s_err_cnt), .fail_seen(s_fail_seen), .first_fail_ab(s_first_ab),
        .first_fail_mask(s_first_mask)
`ifdef GATE_RESP_CHECKER_COVER_EN
       ,.cover_map(s_cover_map)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Golden gate values from arithmetic on 0/1 integers.
    function automatic logic [6:0] ref_gates(input logic ra, input logic rb);
        int ia, ib, v_or, v_and, v_xor;
        ia    = ra ? 1 : 0;
        ib    = rb ? 1 : 0;
        v_or  = (ia + ib > 0) ? 1 : 0;
        v_and = ia * ib;
        v_xor = (ia + ib) % 2;
        return {1'(1 - ia), 1'(1 - v_or), 1'(v_or), 1'(v_and),
                1'(1 - v_and), 1'(v_xor), 1'(1 - v_xor)};
    endfunction

    // Behavioural model, one slot per instance.
    int         nv[2]   = '{4, 6};
    int         emax[2] = '{255, 3};
    bit         m_run[2], m_done[2], m_fs[2];
    int         m_vec[2], m_err[2];
    logic [1:0] m_ab[2];
    logic [6:0] m_mask[2];
    logic [3:0] m_cov[2];

    task automatic model_step(input int k, input logic r, input logic st, input logic v,
                              input logic ma, input logic mb, input logic [6:0] g);
        logic [6:0] diff;
        if (r) begin
            m_run[k] = 0; m_done[k] = 0; m_fs[k] = 0;
            m_vec[k] = 0; m_err[k] = 0; m_ab[k] = '0; m_mask[k] = '0; m_cov[k] = '0;
        end else if (!m_run[k]) begin
            if (st) begin
                m_run[k] = 1; m_done[k] = 0; m_fs[k] = 0;
                m_vec[k] = 0; m_err[k] = 0; m_ab[k] = '0; m_mask[k] = '0; m_cov[k] = '0;
            end
        end else if (v) begin
            diff = g ^ ref_gates(ma, mb);
            m_vec[k]++;
            m_cov[k][{ma, mb}] = 1'b1;
            if (diff != 0) begin
                if (m_err[k] < emax[k]) m_err[k]++;
                if (!m_fs[k]) begin
                    m_fs[k] = 1; m_ab[k] = {ma, mb}; m_mask[k] = diff;
                end
            end
            if (m_vec[k] == nv[k]) begin
                m_run[k] = 0; m_done[k] = 1;
            end
        end
    endtask

    function automatic bit model_pass(input int k);
`ifdef GATE_RESP_CHECKER_COVER_EN
        return m_done[k] && m_err[k] == 0 && m_cov[k] == 4'b1111;
`else
        return m_done[k] && m_err[k] == 0;
`endif
    endfunction

    task automatic cmp_model(input int k, input logic bz, input logic dn, input logic ps,
                             input int vc, input int ec, input logic fs,
                             input logic [1:0] fab, input logic [6:0] fm, input logic [3:0] cm);
        check($sformatf("m%0d busy", k), bz, m_run[k]);
        check($sformatf("m%0d done", k), dn, m_done[k]);
        check($sformatf("m%0d pass", k), ps, model_pass(k));
        check($sformatf("m%0d vec_cnt", k), vc, m_vec[k]);
        check($sformatf("m%0d err_cnt", k), ec, m_err[k]);
        check($sformatf("m%0d fail_seen", k), fs, m_fs[k]);
        check($sformatf("m%0d first_ab", k), fab, m_ab[k]);
        check($sformatf("m%0d first_mask", k), fm, m_mask[k]);
`ifdef GATE_RESP_CHECKER_COVER_EN
        check($sformatf("m%0d cover_map", k), cm, m_cov[k]);
`else
        if (cm !== 4'b0000) check($sformatf("m%0d cover_map", k), cm, 0);
`endif
    endtask

    task automatic cmp_main();
        cmp_model(0, busy, done, pass, int'(vec_cnt), int'(err_cnt), fail_seen,
                  first_fail_ab, first_fail_mask, cover_map);
    endtask

    task automatic cmp_sat();
        cmp_model(1, s_busy, s_done, s_pass, int'(s_vec_cnt), int'(s_err_cnt), s_fail_seen,
                  s_first_ab, s_first_mask, s_cover_map);
    endtask

    // One clock edge: model follows the driven inputs, outputs sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        model_step(0, rst, start, in_valid, a, b, gates);
        model_step(1, rst, s_start, s_valid, s_a, s_b, s_gates);
        #1;
    endtask

    task automatic drive(input logic st, input logic v, input logic [1:0] ab, input logic [6:0] flt);
        start    = st;
        in_valid = v;
        {a, b}   = ab;
        gates    = ref_gates(ab[1], ab[0]) ^ flt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 2'b00, 7'h00);
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic       st;
        logic       v;
        logic [1:0] ab;
        logic [6:0] flt;
        logic       e_busy, e_done, e_pass;
        int         e_vec, e_err;
        logic       e_fs;
        logic [1:0] e_fab;
        logic [6:0] e_fmask;
    } row_t;

    row_t tbl[$];

    initial begin
        // clean run 00,01,10,11
        tbl.push_back(row_t'{1,0,2'd0,7'h00, 1,0,0, 0,0, 0,2'd0,7'h00});
        tbl.push_back(row_t'{0,1,2'd0,7'h00, 1,0,0, 1,0, 0,2'd0,7'h00});
        tbl.push_back(row_t'{0,1,2'd1,7'h00, 1,0,0, 2,0, 0,2'd0,7'h00});
        tbl.push_back(row_t'{0,1,2'd2,7'h00, 1,0,0, 3,0, 0,2'd0,7'h00});
        tbl.push_back(row_t'{0,1,2'd3,7'h00, 0,1,1, 4,0, 0,2'd0,7'h00});
        tbl.push_back(row_t'{0,1,2'd1,7'h7F, 0,1,1, 4,0, 0,2'd0,7'h00}); // ignored in DONE
        // xor_g forced to 0 at 01
        tbl.push_back(row_t'{1,0,2'd0,7'h00, 1,0,0, 0,0, 0,2'd0,7'h00});
        tbl.push_back(row_t'{0,1,2'd0,7'h00, 1,0,0, 1,0, 0,2'd0,7'h00});
        tbl.push_back(row_t'{0,1,2'd1,7'h02, 1,0,0, 2,1, 1,2'd1,7'h02});
        tbl.push_back(row_t'{0,1,2'd2,7'h00, 1,0,0, 3,1, 1,2'd1,7'h02});
        tbl.push_back(row_t'{0,1,2'd3,7'h00, 0,1,0, 4,1, 1,2'd1,7'h02});
        // and_g flipped at 10, nand_g flipped at 11
        tbl.push_back(row_t'{1,0,2'd0,7'h00, 1,0,0, 0,0, 0,2'd0,7'h00});
        tbl.push_back(row_t'{0,1,2'd0,7'h00, 1,0,0, 1,0, 0,2'd0,7'h00});
        tbl.push_back(row_t'{0,1,2'd1,7'h00, 1,0,0, 2,0, 0,2'd0,7'h00});
        tbl.push_back(row_t'{0,1,2'd2,7'h08, 1,0,0, 3,1, 1,2'd2,7'h08});
        tbl.push_back(row_t'{0,1,2'd3,7'h04, 0,1,0, 4,2, 1,2'd2,7'h08});
        // start with in_valid in DONE: run starts, vector not counted
        tbl.push_back(row_t'{1,1,2'd0,7'h7F, 1,0,0, 0,0, 0,2'd0,7'h00});

        do_reset();
        cmp_main();
        cmp_sat();

        // ---- table-driven vectors
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].v, tbl[i].ab, tbl[i].flt);
            tick();
            check($sformatf("row%0d busy", i),  busy,            tbl[i].e_busy);
            check($sformatf("row%0d done", i),  done,            tbl[i].e_done);
            check($sformatf("row%0d pass", i),  pass,            tbl[i].e_pass);
            check($sformatf("row%0d vec", i),   vec_cnt,         tbl[i].e_vec);
            check($sformatf("row%0d err", i),   err_cnt,         tbl[i].e_err);
            check($sformatf("row%0d fs", i),    fail_seen,       tbl[i].e_fs);
            check($sformatf("row%0d fab", i),   first_fail_ab,   tbl[i].e_fab);
            check($sformatf("row%0d fmask", i), first_fail_mask, tbl[i].e_fmask);
        end
        drive(0, 0, 2'b00, 7'h00);

        // ---- gaps, in_valid before start, start mid-run
        do_reset();
        drive(0, 1, 2'b11, 7'h00); tick();
        drive(0, 1, 2'b10, 7'h00); tick();
        check("pre-start vec", vec_cnt, 0);
        check("pre-start busy", busy, 0);
        drive(1, 0, 2'b00, 7'h00); tick();
        drive(0, 1, 2'b00, 7'h00); tick(); cmp_main();
        drive(0, 0, 2'b00, 7'h00); tick(); cmp_main();
        drive(0, 1, 2'b01, 7'h00); tick(); cmp_main();
        drive(1, 1, 2'b10, 7'h00); tick(); cmp_main();
        check("mid-start vec", vec_cnt, 3);
        check("mid-start busy", busy, 1);
        drive(0, 0, 2'b00, 7'h00); tick(); cmp_main();
        drive(0, 1, 2'b11, 7'h00); tick(); cmp_main();
        check("gaps done", done, 1);
        check("gaps vec", vec_cnt, 4);
        check("gaps busy", busy, 0);

        // ---- reset mid-run after 2 vectors, then clean run
        drive(1, 0, 2'b00, 7'h00); tick();
        drive(0, 1, 2'b00, 7'h01); tick();
        drive(0, 1, 2'b01, 7'h00); tick();
        do_reset();
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst vec", vec_cnt, 0);
        check("rst err", err_cnt, 0);
        check("rst fs", fail_seen, 0);
        check("rst mask", first_fail_mask, 0);
        cmp_main();
        drive(0, 0, 2'b00, 7'h00); tick();
        check("rst no done", done, 0);
        drive(1, 0, 2'b00, 7'h00); tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 2'(i), 7'h00); tick();
        end
        check("after-rst done", done, 1);
        check("after-rst pass", pass, 1);
        cmp_main();

        // ---- cover variant run: 00,00,01,01 clean
        drive(1, 0, 2'b00, 7'h00); tick();
        drive(0, 1, 2'b00, 7'h00); tick();
        drive(0, 1, 2'b00, 7'h00); tick();
        drive(0, 1, 2'b01, 7'h00); tick();
        drive(0, 1, 2'b01, 7'h00); tick();
        check("cov done", done, 1);
        check("cov err", err_cnt, 0);
`ifdef GATE_RESP_CHECKER_COVER_EN
        check("cov map", cover_map, 4'b0011);
        check("cov pass", pass, 0);
`else
        check("cov pass", pass, 1);
`endif
        drive(0, 0, 2'b00, 7'h00);

        // ---- saturation: NUM_VECTORS=6, ERR_W=2, every vector faulty
        s_start = 1'b1; tick(); s_start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            s_valid = 1'b1;
            {s_a, s_b} = 2'(i % 4);
            s_gates = ref_gates(s_a, s_b) ^ 7'h40;
            tick();
            check($sformatf("sat err v%0d", i), s_err_cnt, (i + 1 < 3) ? i + 1 : 3);
        end
        s_valid = 1'b0;
        check("sat done", s_done, 1);
        check("sat pass", s_pass, 0);
        check("sat vec", s_vec_cnt, 6);
        check("sat first mask", s_first_mask, 7'h40);
        cmp_sat();

        // ---- randomized traffic against the model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [1:0] rab;
            logic [6:0] flt;
            rab = 2'($urandom_range(3));
            flt = ($urandom_range(3) == 0) ? 7'($urandom_range(127)) : 7'h00;
            rst = ($urandom_range(99) == 0);
            drive(($urandom_range(11) == 0), ($urandom_range(2) != 0), rab, flt);
            s_start = ($urandom_range(9) == 0);
            s_valid = ($urandom_range(1) == 0);
            {s_a, s_b} = 2'($urandom_range(3));
            s_gates = ref_gates(s_a, s_b) ^ (($urandom_range(1) == 0) ? 7'h11 : 7'h00);
            tick();
            cmp_main();
            cmp_sat();
        end
        rst = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
